// File: rtl/timer_pkg.sv
// Shared types, digit layout and BCD validity check for the hh:mm:ss.mmm timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_DIGITS = 9;

  // Nibble offsets within the 36-bit count, MSB first
  localparam int unsigned OFS_HR_T  = 32;
  localparam int unsigned OFS_HR_O  = 28;
  localparam int unsigned OFS_MIN_T = 24;
  localparam int unsigned OFS_MIN_O = 20;
  localparam int unsigned OFS_SEC_T = 16;
  localparam int unsigned OFS_SEC_O = 12;
  localparam int unsigned OFS_MS_H  = 8;
  localparam int unsigned OFS_MS_T  = 4;
  localparam int unsigned OFS_MS_O  = 0;

  localparam logic [3:0] DEC_MAX = 4'd9;
  localparam logic [3:0] SEX_MAX = 4'd5;

  // Per-digit roll-over value, digit 0 = ms ones
  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == OFS_SEC_T / 4 || idx == OFS_MIN_T / 4) ? SEX_MAX : DEC_MAX;
  endfunction

  function automatic logic bcd_valid(input logic [35:0] v, input int unsigned hour_max);
    logic        ok;
    int unsigned hours;
    ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] > digit_max(i)) ok = 1'b0;
    end
    hours = 32'(v[OFS_HR_T +: 4]) * 32'd10 + 32'(v[OFS_HR_O +: 4]);
    if (hours > hour_max) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with wrap at MAX; carry/borrow pulse when wrapping.
module bcd_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = DEC_MAX
) (
  input  logic       clk_i,
  input  logic       resetn,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] q_d, q_q;

  // Next digit value: load wins, otherwise step with wrap
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i) begin
      q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
    end else if (dec_i) begin
      q_d = (q_q == '0) ? MAX : q_q - 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o      = q_q;
  assign carry_o  = inc_i & ~load_i & (q_q == MAX);
  assign borrow_o = dec_i & ~load_i & (q_q == '0);

endmodule

// File: rtl/bcd_timer.sv
// hh:mm:ss.mmm BCD up/down timer with tick prescaler, validated load and
// sticky terminal-count flag. Optional lap capture under BCD_TIMER_LAP_EN.
module bcd_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 100000,
  parameter int unsigned HOUR_MAX     = 99
) (
  input  logic        clk_i,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [35:0] load_val_i,
  input  logic        up_i,
  output logic [35:0] count_o,
  output logic        running_o,
  output logic        done_o,
  output logic        load_err_o
`ifdef BCD_TIMER_LAP_EN
  ,
  input  logic        lap_i,
  output logic [35:0] lap_o
`endif
);

  localparam int unsigned     PW         = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_TICK - 1);
  localparam logic [35:0]     COUNT_MAX  = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10),
                                            SEX_MAX, DEC_MAX, SEX_MAX, DEC_MAX,
                                            DEC_MAX, DEC_MAX, DEC_MAX};
  // One ms before the terminal values: the tick from here lands on terminal
  localparam logic [35:0]     COUNT_PRE_MAX = {COUNT_MAX[35:4], 4'd8};
  localparam logic [35:0]     COUNT_ONE     = 36'd1;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          err_q, err_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [35:0]   count_q;
  logic [35:0]   dig_load_val;
  logic          dig_load;
  logic          load_ok;
  logic          counting;
  logic          tick;
  logic          start_blocked;
  logic          term_hit;

  assign load_ok       = bcd_valid(load_val_i, HOUR_MAX);
  assign start_blocked = up_i ? (count_q == COUNT_MAX) : (count_q == '0);

  // Counting continues in RUN unless a higher-priority command takes effect
  always_comb begin
    counting = 1'b0;
    if (state_q == ST_RUN) begin
      if (clear_i)     counting = 1'b0;
      else if (load_i) counting = ~load_ok;
      else             counting = ~stop_i;
    end
    tick = counting & (presc_q == PRESC_LAST);
  end

  // Digit chain: ms ones first, carries/borrows ripple upward
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic inc_in, dec_in, carry, borrow;
    if (g == 0) begin : g_lsd
      assign inc_in = tick & mode_q;
      assign dec_in = tick & ~mode_q;
    end else begin : g_chain
      assign inc_in = g_dig[g-1].carry;
      assign dec_in = g_dig[g-1].borrow;
    end
    bcd_digit #(.MAX(digit_max(g))) u_digit (
      .clk_i      (clk_i),
      .resetn     (resetn),
      .inc_i      (inc_in),
      .dec_i      (dec_in),
      .load_i     (dig_load),
      .load_val_i (dig_load_val[g*4 +: 4]),
      .q_o        (count_q[g*4 +: 4]),
      .carry_o    (carry),
      .borrow_o   (borrow)
    );
  end

  // Terminal detection from the pre-tick count; a top-digit wrap also stops the count
  assign term_hit = tick & ((mode_q ? (count_q == COUNT_PRE_MAX) : (count_q == COUNT_ONE))
                            | g_dig[NUM_DIGITS-1].carry | g_dig[NUM_DIGITS-1].borrow);

  // Command decode (clear > load > stop > start), prescaler and terminal handling
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    done_d       = done_q;
    presc_d      = presc_q;
    err_d        = 1'b0;
    dig_load     = 1'b0;
    dig_load_val = load_val_i;
    if (clear_i) begin
      dig_load     = 1'b1;
      dig_load_val = '0;
      done_d       = 1'b0;
      presc_d      = '0;
      state_d      = ST_IDLE;
    end else if (load_i) begin
      if (load_ok) begin
        dig_load = 1'b1;
        done_d   = 1'b0;
        state_d  = ST_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (stop_i) begin
      if (state_q == ST_RUN) state_d = ST_IDLE;
    end else if (start_i) begin
      if (state_q != ST_RUN && !start_blocked) begin
        state_d = ST_RUN;
        mode_d  = up_i;
        done_d  = 1'b0;
        presc_d = '0;
      end
    end
    if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (term_hit) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
    running_d = (state_d == ST_RUN);
  end

  // Control registers
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      running_q <= running_d;
      err_q     <= err_d;
      presc_q   <= presc_d;
    end
  end

  assign count_o    = count_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign load_err_o = err_q;

`ifdef BCD_TIMER_LAP_EN
  logic [35:0] lap_q, lap_d;

  // Lap capture of the current count while running
  always_comb begin
    lap_d = lap_q;
    if (clear_i)                          lap_d = '0;
    else if (lap_i && state_q == ST_RUN)  lap_d = count_q;
  end

  // Lap register
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) lap_q <= '0;
    else         lap_q <= lap_d;
  end

  assign lap_o = lap_q;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer (CLK_PER_TICK=4, HOUR_MAX=99).
module tb_bcd_timer;

  logic        clk_i = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, load_i = 1'b0, up_i = 1'b0;
  logic [35:0] load_val_i = '0;
  logic [35:0] count_o, lap_w;
  logic        running_o, done_o, load_err_o;
`ifdef BCD_TIMER_LAP_EN
  logic        lap_i = 1'b0;
`endif

  bcd_timer #(.CLK_PER_TICK(4), .HOUR_MAX(99)) dut (
    .clk_i      (clk_i),
    .resetn     (resetn),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .up_i       (up_i),
    .count_o    (count_o),
    .running_o  (running_o),
    .done_o     (done_o),
    .load_err_o (load_err_o)
`ifdef BCD_TIMER_LAP_EN
    ,
    .lap_i      (lap_i),
    .lap_o      (lap_w)
`endif
  );
`ifndef BCD_TIMER_LAP_EN
  assign lap_w = '0;
`endif

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [35:0] lap;
    logic [35:0] count;
    logic        run;
    logic        done;
    logic        err;
  } snap_t;

  typedef struct {
    snap_t s;
    int    at;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic expect_snap(input logic [35:0] c, input logic r, input logic d, input logic e,
                             input int at, input logic [35:0] lp);
    exp_t x;
    x.s.lap   = lp;
    x.s.count = c;
    x.s.run   = r;
    x.s.done  = d;
    x.s.err   = e;
    x.at      = at;
    q.push_back(x);
  endtask

  // One-cycle command; t0 is the cycle count when it was driven
  task automatic cmd(input logic s, input logic p, input logic c, input logic l,
                     input logic up, input logic [35:0] v, output int t0);
    @(negedge clk_i);
    start_i = s; stop_i = p; clear_i = c; load_i = l; up_i = up; load_val_i = v;
    t0 = cyc;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
  endtask

  // Monitor: every change of the observable outputs consumes one expectation
  initial begin
    snap_t prev, cur;
    exp_t  e;
    prev = '1;
    forever begin
      @(negedge clk_i or negedge resetn);
      #1;
      cur = {lap_w, count_o, running_o, done_o, load_err_o};
      if (cur !== prev) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got=%h required=none cycle=%0d", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.s) begin
            n_fail++;
            $display("FAIL snapshot got=%h required=%h cycle=%0d", cur, e.s, cyc);
          end
          if (e.at >= 0) begin
            n_chk++;
            if (cyc != e.at) begin
              n_fail++;
              $display("FAIL timing got_cycle=%0d required_cycle=%0d", cyc, e.at);
            end
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t;
    expect_snap('0, 0, 0, 0, -1, '0);  // reset state
    repeat (3) @(negedge clk_i);
    resetn = 1'b1;

    // Countdown from 3 ms to terminal
    cmd(0, 0, 0, 1, 0, 36'h000000003, t);
    expect_snap(36'h000000003, 0, 0, 0, t + 1, '0);
    cmd(1, 0, 0, 0, 0, '0, t);
    expect_snap(36'h000000003, 1, 0, 0, t + 1, '0);
    expect_snap(36'h000000002, 1, 0, 0, t + 5, '0);
    expect_snap(36'h000000001, 1, 0, 0, t + 9, '0);
    expect_snap(36'h000000000, 0, 1, 0, t + 13, '0);
    repeat (20) @(negedge clk_i);
    cmd(1, 0, 0, 0, 0, '0, t);         // down start at zero: ignored
    repeat (6) @(negedge clk_i);

    // Up across a minute boundary, then stop
    cmd(0, 0, 0, 1, 0, 36'h000059999, t);
    expect_snap(36'h000059999, 0, 0, 0, t + 1, '0);
    cmd(1, 0, 0, 0, 1, '0, t);
    expect_snap(36'h000059999, 1, 0, 0, t + 1, '0);
    expect_snap(36'h000100000, 1, 0, 0, t + 5, '0);
    repeat (5) @(negedge clk_i);
    cmd(0, 1, 0, 0, 0, '0, t);
    expect_snap(36'h000100000, 0, 0, 0, t + 1, '0);

    // Up to saturation at 99:59:59.999
    cmd(0, 0, 0, 1, 0, 36'h995959998, t);
    expect_snap(36'h995959998, 0, 0, 0, t + 1, '0);
    cmd(1, 0, 0, 0, 1, '0, t);
    expect_snap(36'h995959998, 1, 0, 0, t + 1, '0);
    expect_snap(36'h995959999, 0, 1, 0, t + 5, '0);
    repeat (8) @(negedge clk_i);
    cmd(1, 0, 0, 0, 1, '0, t);         // up start at max: ignored
    repeat (6) @(negedge clk_i);

    // Invalid load (seconds tens = 6)
    cmd(0, 0, 0, 1, 0, 36'h000060000, t);
    expect_snap(36'h995959999, 0, 1, 1, t + 1, '0);
    expect_snap(36'h995959999, 0, 1, 0, t + 2, '0);
    repeat (4) @(negedge clk_i);

    // Clear, then start+stop together stays idle
    cmd(0, 0, 1, 0, 0, '0, t);
    expect_snap('0, 0, 0, 0, t + 1, '0);
    cmd(1, 1, 0, 0, 1, '0, t);
    repeat (8) @(negedge clk_i);

    // Run up, then clear+load together mid-run
    cmd(1, 0, 0, 0, 1, '0, t);
    expect_snap(36'h000000000, 1, 0, 0, t + 1, '0);
    expect_snap(36'h000000001, 1, 0, 0, t + 5, '0);
    expect_snap(36'h000000002, 1, 0, 0, t + 9, '0);
    repeat (8) @(negedge clk_i);
    cmd(0, 0, 1, 1, 0, 36'h000000555, t);
    expect_snap('0, 0, 0, 0, t + 1, '0);

    // Asynchronous reset mid-run, borrowing across digits first
    cmd(0, 0, 0, 1, 0, 36'h000000100, t);
    expect_snap(36'h000000100, 0, 0, 0, t + 1, '0);
    cmd(1, 0, 0, 0, 0, '0, t);
    expect_snap(36'h000000100, 1, 0, 0, t + 1, '0);
    expect_snap(36'h000000099, 1, 0, 0, t + 5, '0);
    repeat (6) @(negedge clk_i);
    expect_snap('0, 0, 0, 0, -1, '0);
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk_i);
    resetn = 1'b1;
    repeat (10) @(negedge clk_i);

`ifdef BCD_TIMER_LAP_EN
    // Lap capture while counting
    begin
      int tl;
      cmd(1, 0, 0, 0, 1, '0, t);
      expect_snap(36'h000000000, 1, 0, 0, t + 1, '0);
      expect_snap(36'h000000001, 1, 0, 0, t + 5, '0);
      repeat (4) @(negedge clk_i);
      @(negedge clk_i);
      lap_i = 1'b1;
      tl = cyc;
      @(negedge clk_i);
      lap_i = 1'b0;
      expect_snap(36'h000000001, 1, 0, 0, tl + 1, 36'h000000001);
      expect_snap(36'h000000002, 1, 0, 0, t + 9, 36'h000000001);
      repeat (4) @(negedge clk_i);
      cmd(0, 0, 1, 0, 0, '0, t);
      expect_snap('0, 0, 0, 0, t + 1, '0);
      repeat (6) @(negedge clk_i);
    end
`endif

    repeat (10) @(negedge clk_i);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised hh:mm:ss.mmm BCD timer: a stopwatch when counting up, a countdown when counting down. It replaces the fixed countdown-only timer. It takes debounced, single-cycle start/stop/load/clear pulses from the button front end and drives the nine-digit BCD value to the display driver. It adds an internal tick prescaler, up/down mode, parallel load with BCD validation, and a terminal-count flag.

## Interface
- CLK_PER_TICK, 100000: clk_i cycles per 1 ms tick; must be ≥ 2.
- HOUR_MAX, 99: highest hour value; legal range 1..99.
- clk_i  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low; clock clk_i.
- start_i  in  1  single-cycle pulse; begin or resume counting.
- stop_i  in  1  single-cycle pulse; pause counting.
- clear_i  in  1  single-cycle pulse; zero the count and stop.
- load_i  in  1  single-cycle pulse; load load_val_i and stop.
- load_val_i  in  36  BCD value to load, same layout as count_o.
- up_i  in  1  1 = count up, 0 = count down; sampled on an accepted start.
- count_o  out  36  BCD value, one digit per nibble, MSB first:
  - [35:32] hours tens, [31:28] hours ones
  - [27:24] minutes tens, [23:20] minutes ones
  - [19:16] seconds tens, [15:12] seconds ones
  - [11:0] ms hundreds/tens/ones
- running_o  out  1  1 while in RUN.
- done_o  out  1  sticky terminal-count flag.
- load_err_o  out  1  one-cycle pulse; load rejected.
- lap_i / lap_o  in 1 / out 36  lap capture; present only with BCD_TIMER_LAP_EN.

## Operation
- States:
  - IDLE: stopped, count held.
  - RUN: counting.
  - DONE: terminal count reached, count held.
- Input priority when several pulses arrive in the same cycle: clear > load > stop > start. The winning pulse fully defines the next state.
- clear: count ← 0, done_o ← 0, go to IDLE. Accepted from any state.
- load:
  - Valid values: every digit ≤ 9, seconds tens ≤ 5, minutes tens ≤ 5, hours ≤ HOUR_MAX.
  - Valid: count ← load_val_i, done_o ← 0, go to IDLE.
  - Invalid: count unchanged, load_err_o pulses, state unchanged.
- start:
  - Accepted from IDLE or DONE. Latches up_i into the mode register, clears done_o, zeroes the prescaler, and goes to RUN.
  - Ignored when up mode is selected and the count is at maximum (HOUR_MAX:59:59.999).
  - Ignored when down mode is selected and the count is 0.
  - Ignored while in RUN.
- stop: RUN → IDLE. The prescaler is held. Ignored in other states.
- On each tick while in RUN, the count moves by 1 ms with ripple carry/borrow:
  - ms rolls 999 → 000; seconds and minutes roll 59 → 00; borrows run in the reverse direction.
  - Up mode: reaching HOUR_MAX:59:59.999 → DONE and done_o ← 1. The count saturates and never wraps.
  - Down mode: reaching 0 → DONE and done_o ← 1.
- up_i changes while in RUN have no effect.

## Timing
- Reset values: every output 0, state IDLE, prescaler 0, mode down.
- Prescaler counts 0..CLK_PER_TICK-1 in RUN only. The tick fires on the wrap to 0.
- The first count change appears on count_o CLK_PER_TICK+1 cycles after the start pulse cycle. Later changes follow every CLK_PER_TICK cycles.
- All outputs are registered. An accepted command is visible on outputs on the next clock edge.
- The terminal count value and done_o assert on the same edge.
- Reset asserted mid-count forces IDLE and count 0 immediately. No tick is generated during reset.

## Configuration
- BCD_TIMER_LAP_EN defined: adds the lap_i/lap_o ports.
  - A lap_i pulse in RUN copies count_o into lap_o on the next edge.
  - clear_i zeroes lap_o; reset value of lap_o is 0.
  - lap_i outside RUN is ignored.
- BCD_TIMER_LAP_EN undefined: the lap ports and register are absent. All other behaviour is identical.

## Structure
- timer_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - nibble field offset constants for the layout above
  - digit limit constants (9, 5)
  - validity-check function for a 36-bit BCD value
- Sub-module bcd_digit: one BCD digit with a MAX parameter.
  - Inputs: inc, dec, load.
  - Outputs: carry/borrow pulses.
  - Instantiated nine times. The hours pair is constrained by HOUR_MAX at top level.

## Test plan
Sim parameters: CLK_PER_TICK=4, HOUR_MAX=99.
- Load 00:00:00.003, down mode, start → count 002, 001, 000 at 4-cycle spacing; done_o=1, running_o=0; further ticks produce no change.
- Load 00:00:59.999, up mode, start → after 1 tick, count_o = 00:01:00.000.
- Load 99:59:59.998, up mode, start → after 1 tick, count = 99:59:59.999 and done_o=1; another start is ignored.
- load_val_i seconds tens = 6 → load_err_o one-cycle pulse, count unchanged.
- Same-cycle pulse pairs:
  - start and stop → state remains IDLE.
  - clear and load in RUN → count 0, state IDLE.
- Reset asserted mid-RUN → all outputs 0 asynchronously.
- With BCD_TIMER_LAP_EN: lap pulse in RUN → lap_o equals count_o of that cycle while counting continues.
